approx_iterative_array_multiplier: RTL

Sequential, parametrised successor to the fixed 8-bit approximate reduction layers. Instead of one hard-wired adder row per partial product, this block reuses a single adder row, one partial-product row per cycle. In each row the low `APPROX_COLS` columns use the approximate full adder and the remaining columns are exact. It sits between the operand source and the accumulation stage behind valid/ready handshakes, and has a per-operation exact/approximate mode.

---
 rtl/approx_iterative_array_multiplier.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/approx_iterative_array_multiplier.sv
// Iterative unsigned multiplier: one shared adder row is reused for one partial-product row per cycle.
// The low APPROX_COLS columns use approximate full adders in approximate mode. APPROX_ARRAY_MULT_ACC_EN adds a product accumulator.
`timescale 1ns/1ps
module approx_iterative_array_multiplier #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 8,
  parameter int ACC_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product_o,
  input  logic                 acc_clr,
  output logic [ACC_W-1:0]     acc_o
);

  localparam int PW = 2 * WIDTH;
  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic            mode_reg;
  logic [PW-1:0]   sum_reg;
  logic [PW-1:0]   product_reg;
  logic [RW-1:0]   row_reg;

  logic            accept;
  logic            row_last;
  logic [PW-1:0]   shifted;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   row_sum;
  logic [PW-1:0]   carry;

  assign accept   = in_valid & in_ready;
  assign row_last = (row_reg == RW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = BUSY;
      BUSY: if (row_last) state_next = DONE;
      DONE: if (out_ready) state_next = in_valid ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign shifted = {{WIDTH{1'b0}}, a_reg} << row_reg;
  assign addend  = b_reg[row_reg] ? shifted : '0;
  assign carry[0] = 1'b0;

  // One ripple row; the carry out of the top column is dropped since it cannot occur exactly
  for (genvar gi = 0; gi < PW; gi++) begin : g_col
    logic x, y, c;
    assign x = sum_reg[gi];
    assign y = addend[gi];
    assign c = carry[gi];
    if (gi < PW - 1) begin : g_carry
      assign carry[gi+1] = (x & y) | (x & c) | (y & c);
    end
    if (gi < APPROX_COLS) begin : g_approx
      assign row_sum[gi] = mode_reg ? (x ^ y) : (x ^ y ^ c);
    end else begin : g_exact
      assign row_sum[gi] = x ^ y ^ c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      mode_reg    <= 1'b0;
      sum_reg     <= '0;
      row_reg     <= '0;
      product_reg <= '0;
    end else if (accept) begin
      a_reg    <= a_i;
      b_reg    <= b_i;
      mode_reg <= approx_en;
      sum_reg  <= '0;
      row_reg  <= '0;
    end else if (state_reg == BUSY) begin
      sum_reg <= row_sum;
      row_reg <= row_reg + 1'b1;
      if (row_last) product_reg <= row_sum;
    end
  end

  assign product_o = product_reg;

`ifdef APPROX_ARRAY_MULT_ACC_EN
  logic             handshake;
  logic [ACC_W-1:0] acc_reg;

  assign handshake = out_valid & out_ready;

  // A clear coinciding with a handshake clears first, then adds the delivered product
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (handshake) begin
      acc_reg <= (acc_clr ? '0 : acc_reg) + ACC_W'(product_reg);
    end else if (acc_clr) begin
      acc_reg <= '0;
    end
  end

  assign acc_o = acc_reg;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign acc_o = '0;
`endif

endmodule
